// File: rtl/program_loader.sv
// program_loader: UART byte-stream boot loader driving instruction memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module program_loader #(
  parameter int          MEM_BYTES      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        write_enable,
  output logic [7:0]  write_data,
  output logic [31:0] write_address,
  output logic        clear_mem,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEN,
    DATA,
    DONE,
    ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t        state;
  logic [23:0]   len;
  logic [AW:0]   cnt;
  logic [7:0]    csum;
  logic [1:0]    idx;
  logic [TW-1:0] timer;

  logic        sync_hit;
  logic        last;
  logic        tmo;
  logic        bad_len;
  logic [31:0] len_full;

  assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
  assign last     = (cnt == len[AW:0]);
  assign tmo      = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign len_full = {rx_data, len};
  assign bad_len  = (len_full == 32'd0) ||
                    (len_full > 32'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      len           <= '0;
      cnt           <= '0;
      csum          <= '0;
      idx           <= '0;
      timer         <= '0;
      write_enable  <= 1'b0;
      write_data    <= '0;
      write_address <= '0;
      clear_mem     <= 1'b0;
      core_hold     <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      clear_mem    <= 1'b0;
      load_done    <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (state != ERROR) begin
            state     <= IDLE;
            core_hold <= 1'b0;
          end
          if (sync_hit) begin
            state      <= CLEAR;
            clear_mem  <= 1'b1;
            core_hold  <= 1'b1;
            load_error <= 1'b0;
          end
        end
        CLEAR: begin
          state <= LEN;
          cnt   <= '0;
          csum  <= '0;
          timer <= '0;
          len   <= {16'h0, rx_valid ? rx_data : 8'h00};
          idx   <= {1'b0, rx_valid};
        end
        LEN: begin
          if (rx_valid) begin
            timer <= '0;
            idx   <= idx + 1'b1;
            unique case (idx)
              2'd0: len[7:0]   <= rx_data;
              2'd1: len[15:8]  <= rx_data;
              2'd2: len[23:16] <= rx_data;
              default: begin
                if (bad_len) begin
                  state      <= ERROR;
                  load_error <= 1'b1;
                end else begin
                  state <= DATA;
                end
              end
            endcase
          end else if (tmo) begin
            state      <= ERROR;
            load_error <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          // last is seen in the cycle of the final write strobe
          if (last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (!rx_valid) begin
              state <= CHECK;
              timer <= timer + 1'b1;
            end else if (rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
              timer      <= '0;
            end
`else
            state     <= DONE;
            load_done <= 1'b1;
            core_hold <= 1'b0;
`endif
          end else if (rx_valid) begin
            timer         <= '0;
            write_enable  <= 1'b1;
            write_data    <= rx_data;
            write_address <= 32'(cnt[AW-1:0]);
            cnt           <= cnt + 1'b1;
            csum          <= csum + rx_data;
          end else if (tmo) begin
            state      <= ERROR;
            load_error <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            timer <= '0;
            if (rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end else if (tmo) begin
            state      <= ERROR;
            load_error <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: frame-level reference checks for program_loader.
// Honours PROGRAM_LOADER_CHECKSUM_EN the same way as the design.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 16;
  localparam int         MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [31:0] write_address;
  logic        clear_mem;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  program_loader #(
    .MEM_BYTES(MEMB),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .write_enable(write_enable),
    .write_data(write_data),
    .write_address(write_address),
    .clear_mem(clear_mem),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  bit          wr_hold_q[$];
  int clr_cnt = 0, done_cnt = 0, clr_cyc = 0, done_cyc = 0, err_cyc = 0;
  bit done_hold = 1'b0;
  bit err_seen = 1'b0;

  always @(negedge clk) begin
    if (write_enable) begin
      wr_addr_q.push_back(write_address);
      wr_data_q.push_back(write_data);
      wr_cyc_q.push_back(cyc);
      wr_hold_q.push_back(core_hold);
    end
    if (clear_mem) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_hold = core_hold;
    end
    if (load_error && !err_seen) begin
      err_seen = 1'b1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         cyc_q[$];

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int maxgap,
                           input bit exp_done, input bit exp_err);
    int w0, d0, c0;
    w0 = wr_data_q.size();
    d0 = done_cnt;
    c0 = clr_cnt;
    cyc_q.delete();
    foreach (tx_q[i]) begin
      put(tx_q[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
    idle(4);
    check({tag, ".nwr"}, wr_data_q.size() - w0, exp_q.size());
    foreach (exp_q[i]) begin
      if (w0 + i < wr_data_q.size()) begin
        check({tag, ".addr"}, wr_addr_q[w0+i], i);
        check({tag, ".data"}, wr_data_q[w0+i], exp_q[i]);
      end
    end
    check({tag, ".done"}, done_cnt - d0, exp_done);
    check({tag, ".clr"}, clr_cnt - c0, 1);
    check({tag, ".err"}, load_error, exp_err);
    check({tag, ".hold"}, core_hold, exp_err);
  endtask

  task automatic rand_frame(input string tag, input logic [31:0] n,
                            input int noise, input bit bad_sum,
                            input int maxgap);
    logic [7:0] b, sum;
    int npay;
    bit ok;
    tx_q.delete();
    exp_q.delete();
    sum = 8'h00;
    repeat (noise) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      tx_q.push_back(b);
    end
    tx_q.push_back(SYNC);
    for (int k = 0; k < 4; k++) tx_q.push_back(n[8*k +: 8]);
    npay = (n >= 1 && n <= MEMB) ? int'(n) : 0;
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_q.push_back(b);
      sum = sum + b;
    end
    ok = (npay > 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (npay > 0) tx_q.push_back(bad_sum ? sum + 8'd1 : sum);
    ok = ok && !bad_sum;
`endif
    run_frame(tag, maxgap, ok, !ok);
  endtask

  initial begin
    int base, w0, c0;
    logic [31:0] n;
    int r;

    repeat (3) @(negedge clk);
    check("rst.we", write_enable, 0);
    check("rst.wd", write_data, 0);
    check("rst.wa", write_address, 0);
    check("rst.clr", clear_mem, 0);
    check("rst.hold", core_hold, 0);
    check("rst.done", load_done, 0);
    check("rst.err", load_error, 0);
    rst_n = 1'b1;
    idle(2);

    // normal back-to-back load with cycle-exact timing
    tx_q = '{SYNC, 8'h04, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'h13, 8'h00, 8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h13);
`endif
    run_frame("norm", 0, 1'b1, 1'b0);
    base = wr_data_q.size() - 4;
    check("norm.clr_cyc", clr_cyc, cyc_q[0] + 1);
    for (int i = 0; i < 4; i++) begin
      check("norm.wcyc", wr_cyc_q[base+i], cyc_q[5+i] + 1);
      check("norm.whold", wr_hold_q[base+i], 1);
    end
    check("norm.done_cyc", done_cyc, wr_cyc_q[base+3] + 1);
    check("norm.done_hold", done_hold, 0);

    rand_frame("over", 32'd1025, 0, 1'b0, 0);
    tx_q = '{SYNC, 8'h01, 8'h00, 8'h00, 8'h00, 8'h7F};
    exp_q = '{8'h7F};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h7F);
`endif
    run_frame("recov", 0, 1'b1, 1'b0);
    rand_frame("zero", 32'd0, 0, 1'b0, 0);
    rand_frame("max", 32'd1024, 0, 1'b0, 0);

    tx_q = '{8'h00, 8'hFF, 8'h3C, SYNC, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h01, 8'h02, 8'h03};
    exp_q = '{8'h01, 8'h02};
    run_frame("noise", 0, 1'b1, 1'b0);
    tx_q = '{8'h00, 8'hFF, 8'h3C, SYNC, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h01, 8'h02, 8'h04};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    run_frame("badsum", 0, 1'b0, 1'b1);
`else
    run_frame("badsum", 0, 1'b1, 1'b0);
`endif

    // timeout after one payload byte
    w0 = wr_data_q.size();
    cyc_q.delete();
    put(SYNC);
    put(8'h02);
    put(8'h00);
    put(8'h00);
    put(8'h00);
    put(8'h11);
    err_seen = 1'b0;
    idle(TMO + 10);
    check("tmo.cyc", err_cyc - cyc_q[5], TMO + 1);
    check("tmo.nwr", wr_data_q.size() - w0, 1);
    check("tmo.addr", wr_addr_q[w0], 0);
    check("tmo.data", wr_data_q[w0], 8'h11);
    check("tmo.err", load_error, 1);
    check("tmo.hold", core_hold, 1);

    // async reset in the middle of a payload
    put(SYNC);
    put(8'h04);
    put(8'h00);
    put(8'h00);
    put(8'h00);
    put(8'hAA);
    put(8'hBB);
    @(posedge clk);
    #2;
    check("arst.pre_we", write_enable, 1);
    w0 = wr_data_q.size();
    c0 = clr_cnt;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("arst.flags", {write_enable, clear_mem, core_hold,
                         load_done, load_error}, 0);
    check("arst.wa", write_address, 0);
    check("arst.wd", write_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'hCC);
    put(8'hDD);
    idle(4);
    check("arst.nwr", wr_data_q.size() - w0, 0);
    check("arst.clr", clr_cnt - c0, 0);
    check("arst.hold", core_hold, 0);

    for (int f = 0; f < 24; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 32'd0;
      else if (r == 1) n = 32'(1025 + $urandom_range(0, 3000));
      else if (r == 2) n = 32'hFFFF_FFFF;
      else             n = 32'($urandom_range(1, 12));
      rand_frame("rnd", n, $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
